// File: rtl/flash_host_cmd_issuer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// flash_host_cmd_issuer_pkg : opcodes, field positions and FSM encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package flash_host_cmd_issuer_pkg;

  localparam int CMD_W  = 128;
  localparam int DATA_W = 256;

  localparam int OPC_HI = 127;
  localparam int OPC_LO = 126;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

  localparam int PAGE_BEATS_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Only WRITE carries a data phase; the reserved opcode behaves like ERASE.
  function automatic logic op_has_data(input logic [1:0] op);
    logic r;
    case (op)
      OP_READ:  r = 1'b0;
      OP_WRITE: r = 1'b1;
      OP_ERASE: r = 1'b0;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flash_done_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// flash_done_buffer : drains the completion FIFO into a one-entry done register
// Rev 1.0
// ----------------------------------------------------------------------------
module flash_done_buffer
  import flash_host_cmd_issuer_pkg::*;
(
  input  logic             clk_200M,
  input  logic             rst,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  input  logic [CMD_W-1:0] fifo_data_i,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [CMD_W-1:0] done_cmd_o,
  output logic             rd_pending_o,
  output logic             capture_o
);

  logic             rd_pending_q;
  logic             done_valid_q;
  logic [CMD_W-1:0] done_cmd_q;

  // Only one read may be in flight, and only into an empty done register.
  assign fifo_rd_en_o = !rst && !fifo_empty_i && !done_valid_q && !rd_pending_q;

  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      rd_pending_q <= 1'b0;
      done_valid_q <= 1'b0;
      done_cmd_q   <= '0;
    end else begin
      rd_pending_q <= fifo_rd_en_o;
      if (rd_pending_q) begin
        done_valid_q <= 1'b1;
        done_cmd_q   <= fifo_data_i;
      end else if (done_valid_q && done_ready_i) begin
        done_valid_q <= 1'b0;
      end
    end
  end

  assign done_valid_o = done_valid_q;
  assign done_cmd_o   = done_cmd_q;
  assign rd_pending_o = rd_pending_q;
  assign capture_o    = rd_pending_q;

endmodule
`default_nettype wire

// File: rtl/flash_host_cmd_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// flash_host_cmd_issuer : FTL-side command/write-data issuer with done buffer
// Rev 1.0
// ----------------------------------------------------------------------------
module flash_host_cmd_issuer
  import flash_host_cmd_issuer_pkg::*;
#(
  parameter int PAGE_BEATS      = PAGE_BEATS_DEFAULT,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 9
) (
  input  logic              clk_200M,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [CMD_W-1:0]  done_cmd,
  input  logic              Cmd_Available,
  output logic              Cmd_In_En,
  output logic [CMD_W-1:0]  Cmd_In,
  output logic              Data_In_En,
  output logic [DATA_W-1:0] Data_In,
  input  logic              Finished_Cmd_FIFO_Empty,
  output logic              Finished_Cmd_Out_En,
  input  logic [CMD_W-1:0]  Finished_Cmd_Out,
  input  logic              ControllerIdle,
  output logic              all_idle,
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_underflow
);

  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(PAGE_BEATS - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                err_q, err_d;
  logic                cmd_en_q, data_en_q, all_idle_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [DATA_W-1:0]   data_q;

  logic w_req_hs, w_wd_hs, w_capture, w_done_valid, w_rd_pending;

  assign req_ready   = !rst && (state_q == ST_IDLE) && Cmd_Available &&
                       (outstanding_q < C_MAX_OUT);
  assign wdata_ready = !rst && (state_q == ST_DATA);
  assign w_req_hs    = req_valid && req_ready;
  assign w_wd_hs     = wdata_valid && wdata_ready;

  flash_done_buffer u_done_buffer (
    .clk_200M     (clk_200M),
    .rst          (rst),
    .fifo_empty_i (Finished_Cmd_FIFO_Empty),
    .fifo_rd_en_o (Finished_Cmd_Out_En),
    .fifo_data_i  (Finished_Cmd_Out),
    .done_valid_o (w_done_valid),
    .done_ready_i (done_ready),
    .done_cmd_o   (done_cmd),
    .rd_pending_o (w_rd_pending),
    .capture_o    (w_capture)
  );

  // A completion with nothing in flight is flagged and never wraps the count.
  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (w_capture && (outstanding_q == '0)) err_d = 1'b1;
    if (w_req_hs && !w_capture) begin
      outstanding_d = outstanding_q + C_ONE;
    end else if (!w_req_hs && w_capture && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - C_ONE;
    end
  end

  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= '0;
      cmd_en_q      <= 1'b0;
      cmd_q         <= '0;
      data_en_q     <= 1'b0;
      data_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      all_idle_q    <= 1'b0;
    end else begin
      cmd_en_q      <= w_req_hs;
      data_en_q     <= w_wd_hs;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      all_idle_q    <= (state_q == ST_IDLE) && (outstanding_q == '0) &&
                       ControllerIdle && !w_done_valid && !w_rd_pending;
      if (w_req_hs) cmd_q  <= req_cmd;
      if (w_wd_hs)  data_q <= wdata;
      case (state_q)
        ST_IDLE: begin
          if (w_req_hs) begin
            beat_cnt_q <= '0;
            state_q    <= op_has_data(req_cmd[OPC_HI:OPC_LO]) ? ST_DATA : ST_GAP;
          end
        end
        ST_DATA: begin
          if (w_wd_hs) begin
            beat_cnt_q <= beat_cnt_q + C_ONE;
            if (beat_cnt_q == C_LAST_BEAT) state_q <= ST_GAP;
          end
        end
        // One settling cycle so Cmd_Available reflects the command just issued.
        ST_GAP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Cmd_In_En     = cmd_en_q;
  assign Cmd_In        = cmd_q;
  assign Data_In_En    = data_en_q;
  assign Data_In       = data_q;
  assign done_valid    = w_done_valid;
  assign outstanding   = outstanding_q;
  assign err_underflow = err_q;
  assign all_idle      = all_idle_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_host_cmd_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_flash_host_cmd_issuer : randomized + directed bench with reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_flash_host_cmd_issuer;

  localparam int PB   = 4;
  localparam int MAXO = 8;

  logic         clk_200M = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [127:0] req_cmd = '0;
  logic         wdata_valid = 1'b0;
  logic         wdata_ready;
  logic [255:0] wdata = '0;
  logic         done_valid;
  logic         done_ready = 1'b1;
  logic [127:0] done_cmd;
  logic         Cmd_Available = 1'b1;
  logic         Cmd_In_En;
  logic [127:0] Cmd_In;
  logic         Data_In_En;
  logic [255:0] Data_In;
  logic         Finished_Cmd_FIFO_Empty = 1'b1;
  logic         Finished_Cmd_Out_En;
  logic [127:0] Finished_Cmd_Out = '0;
  logic         ControllerIdle = 1'b1;
  logic         all_idle;
  logic [8:0]   outstanding;
  logic         err_underflow;

  always #5 clk_200M = ~clk_200M;

  flash_host_cmd_issuer #(.PAGE_BEATS(PB), .MAX_OUTSTANDING(MAXO), .CNT_W(9)) dut (
    .clk_200M(clk_200M), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .done_valid(done_valid), .done_ready(done_ready), .done_cmd(done_cmd),
    .Cmd_Available(Cmd_Available), .Cmd_In_En(Cmd_In_En), .Cmd_In(Cmd_In),
    .Data_In_En(Data_In_En), .Data_In(Data_In),
    .Finished_Cmd_FIFO_Empty(Finished_Cmd_FIFO_Empty),
    .Finished_Cmd_Out_En(Finished_Cmd_Out_En), .Finished_Cmd_Out(Finished_Cmd_Out),
    .ControllerIdle(ControllerIdle), .all_idle(all_idle),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  function automatic logic [127:0] cpl_of(input logic [127:0] c);
    return c ^ 128'h5A5A_0000_1234;
  endfunction

  // Reference model: progress of the current command as counts, a scoreboard
  // of issued commands awaiting completion, and the controller's completion FIFO.
  int           m_beats_left, m_out;
  bit           m_gap, m_err, m_dv, m_rdp, m_cmd_en, m_data_en, m_all_idle, pop_now;
  logic [127:0] m_done_word, m_rd_word, m_cmd_word;
  logic [255:0] m_data_word;
  logic [127:0] ctrl_q[$];
  logic [127:0] fifo_q[$];
  bit           hold_cpl = 1'b0;
  int           rel_budget = 0;
  bit           inject = 1'b0;

  task automatic model_reset();
    m_beats_left = 0; m_out = 0; m_gap = 0; m_err = 0; m_dv = 0; m_rdp = 0;
    m_cmd_en = 0; m_data_en = 0; m_all_idle = 0; pop_now = 0;
    ctrl_q.delete(); fifo_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk_200M); #1;
      if (rst) begin
        model_reset();
      end else begin : cmp_body
        bit idle, e_rr, e_wr, e_st, hs, wh, cap;
        idle = (m_beats_left == 0) && !m_gap;
        e_rr = idle && Cmd_Available && (m_out < MAXO);
        e_wr = (m_beats_left > 0);
        e_st = (fifo_q.size() > 0) && !m_dv && !m_rdp;
        chk("req_ready", req_ready, e_rr);
        chk("wdata_ready", wdata_ready, e_wr);
        chk("cpl_strobe", Finished_Cmd_Out_En, e_st);
        chk("cmd_en", Cmd_In_En, m_cmd_en);
        if (m_cmd_en) chk("cmd_in", Cmd_In, m_cmd_word);
        chk("data_en", Data_In_En, m_data_en);
        if (m_data_en) chk("data_in", Data_In, m_data_word);
        chk("done_valid", done_valid, m_dv);
        if (m_dv) chk("done_cmd", done_cmd, m_done_word);
        chk("outstanding", outstanding, m_out);
        chk("err_underflow", err_underflow, m_err);
        chk("all_idle", all_idle, m_all_idle);

        hs  = req_valid && e_rr;
        wh  = wdata_valid && e_wr;
        cap = m_rdp;
        m_all_idle = idle && (m_out == 0) && ControllerIdle && !m_dv && !m_rdp;
        if (cap && m_out == 0) m_err = 1;
        if (hs && !cap) m_out++;
        else if (cap && !hs && m_out > 0) m_out--;
        if (cap) begin
          m_dv = 1; m_done_word = m_rd_word;
        end else if (m_dv && done_ready) begin
          m_dv = 0;
        end
        m_rdp = e_st;
        pop_now = e_st;
        m_cmd_en = hs;
        if (hs) begin
          m_cmd_word = req_cmd;
          ctrl_q.push_back(cpl_of(req_cmd));
        end
        m_data_en = wh;
        if (wh) m_data_word = wdata;
        if (m_gap) m_gap = 0;
        else if (m_beats_left > 0) begin
          if (wh) begin
            m_beats_left--;
            if (m_beats_left == 0) m_gap = 1;
          end
        end else if (hs) begin
          if (req_cmd[127:126] == 2'b01) m_beats_left = PB;
          else m_gap = 1;
        end
      end
      @(posedge clk_200M); #1;
      if (!rst) begin
        if (pop_now) begin
          m_rd_word = fifo_q.pop_front();
          Finished_Cmd_Out = m_rd_word;
          pop_now = 0;
        end
        if (ctrl_q.size() > 0 && (hold_cpl ? (rel_budget > 0) : ($urandom_range(2) == 0))) begin
          fifo_q.push_back(ctrl_q.pop_front());
          if (hold_cpl) rel_budget--;
        end
        if (inject) begin
          fifo_q.push_back(128'hDEAD_BEEF);
          inject = 0;
        end
      end
      Finished_Cmd_FIFO_Empty = (fifo_q.size() == 0);
    end
  end

  task automatic issue(input logic [127:0] c, output bit ok);
    ok = 0;
    @(negedge clk_200M);
    req_cmd = c; req_valid = 1;
    for (int i = 0; i < 50; i++) begin
      #2;
      if (req_ready) begin ok = 1; break; end
      @(negedge clk_200M);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    @(negedge clk_200M);
    hold_cpl = 0; req_valid = 0; wdata_valid = 1; done_ready = 1; Cmd_Available = 1;
    for (int i = 0; i < 400; i++) begin
      #2;
      if (m_out == 0 && !m_dv && !m_rdp && fifo_q.size() == 0 && ctrl_q.size() == 0 &&
          m_beats_left == 0 && !m_gap) begin
        ok = 1; break;
      end
      @(negedge clk_200M);
    end
    chk("drain_timeout", ok, 1);
    @(negedge clk_200M);
    wdata_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] c, first;
    bit ok, acc, st;
    int pulses, strobes;

    repeat (3) @(negedge clk_200M);
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_cmd_en", Cmd_In_En, 0);
    chk("rst_cmd_in", Cmd_In, 0);
    chk("rst_data_en", Data_In_En, 0);
    chk("rst_cpl_strobe", Finished_Cmd_Out_En, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_all_idle", all_idle, 0);
    @(negedge clk_200M);
    rst = 0;

    // ERASE issue
    hold_cpl = 1;
    @(negedge clk_200M);
    c = rnd128(); c[127:126] = 2'b10;
    req_cmd = c; req_valid = 1;
    #2 chk("erase_req_ready", req_ready, 1);
    @(negedge clk_200M);
    req_valid = 0;
    #2;
    chk("erase_cmd_en", Cmd_In_En, 1);
    chk("erase_cmd_in", Cmd_In, c);
    chk("erase_outstanding", outstanding, 1);
    chk("erase_gap_ready", req_ready, 0);
    drain();

    // WRITE with early beats and bubbles
    @(negedge clk_200M);
    wdata_valid = 1; wdata = rnd256();
    #2 chk("early_wdata_ready", wdata_ready, 0);
    @(negedge clk_200M);
    #2 chk("early_data_en", Data_In_En, 0);
    @(negedge clk_200M);
    wdata_valid = 0;
    c = rnd128(); c[127:126] = 2'b01;
    req_cmd = c; req_valid = 1;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_200M);
      req_valid = 0;
      wdata_valid = i[0];
      wdata = rnd256();
      #2 if (Data_In_En) pulses++;
    end
    chk("write_beat_count", pulses, PB);
    drain();

    // Fill to MAX_OUTSTANDING, then release one completion while done_ready=0
    hold_cpl = 1; done_ready = 0; rel_budget = 0;
    first = '0;
    for (int k = 0; k < MAXO; k++) begin
      c = rnd128(); c[127:126] = 2'b00;
      if (k == 0) first = c;
      issue(c, ok);
      chk("issue_read", ok, 1);
    end
    @(negedge clk_200M);
    req_valid = 0;
    @(negedge clk_200M);
    c = rnd128(); c[127:126] = 2'b00;
    req_cmd = c; req_valid = 1;
    #2;
    chk("full_req_ready", req_ready, 0);
    chk("full_outstanding", outstanding, MAXO);
    rel_budget = 2;
    strobes = 0; acc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_200M);
      if (acc) req_valid = 0;
      #2;
      if (Finished_Cmd_Out_En) strobes++;
      if (req_valid && req_ready) acc = 1;
    end
    chk("held_strobe_count", strobes, 1);
    chk("held_done_valid", done_valid, 1);
    chk("held_done_cmd", done_cmd, cpl_of(first));
    chk("ninth_accepted", acc, 1);
    chk("refill_outstanding", outstanding, MAXO);
    @(negedge clk_200M);
    req_valid = 0; done_ready = 1;
    drain();

    // Completion capture coincident with a request handshake
    hold_cpl = 1; rel_budget = 0;
    c = rnd128(); c[127:126] = 2'b00;
    issue(c, ok);
    chk("issue_a", ok, 1);
    @(negedge clk_200M);
    req_valid = 0;
    @(negedge clk_200M);
    rel_budget = 1;
    st = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_200M);
      #2;
      if (Finished_Cmd_Out_En) begin st = 1; break; end
    end
    chk("coinc_strobe_seen", st, 1);
    @(negedge clk_200M);
    c = rnd128(); c[127:126] = 2'b11;
    req_cmd = c; req_valid = 1;
    #2 chk("coinc_req_ready", req_ready, 1);
    @(negedge clk_200M);
    req_valid = 0;
    #2 chk("coinc_outstanding", outstanding, 1);
    drain();

    // Underflow: completion with nothing in flight
    @(negedge clk_200M);
    inject = 1;
    repeat (6) @(negedge clk_200M);
    #2;
    chk("underflow_err", err_underflow, 1);
    chk("underflow_outstanding", outstanding, 0);
    repeat (10) @(negedge clk_200M);
    #2 chk("underflow_sticky", err_underflow, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_200M);
      req_valid     = ($urandom_range(1) == 1);
      req_cmd       = rnd128();
      wdata_valid   = ($urandom_range(2) != 0);
      wdata         = rnd256();
      done_ready    = ($urandom_range(3) != 0);
      Cmd_Available = ($urandom_range(7) != 0);
      ControllerIdle = ($urandom_range(1) == 1);
    end
    ControllerIdle = 1;
    drain();

    // Reset in the middle of a write page
    @(negedge clk_200M);
    c = rnd128(); c[127:126] = 2'b01;
    req_cmd = c; req_valid = 1;
    @(negedge clk_200M);
    req_valid = 0; wdata_valid = 1; wdata = rnd256();
    @(negedge clk_200M);
    wdata = rnd256();
    #3 rst = 1;
    #1;
    chk("midrst_data_en", Data_In_En, 0);
    chk("midrst_data_in", Data_In, 0);
    chk("midrst_cmd_en", Cmd_In_En, 0);
    chk("midrst_wdata_ready", wdata_ready, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_err", err_underflow, 0);
    chk("midrst_all_idle", all_idle, 0);
    @(negedge clk_200M);
    #2 chk("inrst_data_en", Data_In_En, 0);
    @(negedge clk_200M);
    rst = 0; ControllerIdle = 1;
    repeat (2) @(negedge clk_200M);
    #2;
    chk("postrst_all_idle", all_idle, 1);
    chk("postrst_data_en", Data_In_En, 0);
    chk("postrst_wdata_ready", wdata_ready, 0);
    @(negedge clk_200M);
    wdata_valid = 0;
    repeat (2) @(negedge clk_200M);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
